// File: rtl/alu_design.sv
// Registered arithmetic/logic unit with a clock enable, double-width result and flags.
// Commands 9/10 in arithmetic mode pass through a two-stage multiply pipeline.
module alu_design #(
  parameter int Width      = 8,
  parameter int cmd_length = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CE,
  input  logic [Width-1:0]        OPA,
  input  logic [Width-1:0]        OPB,
  input  logic [1:0]              INP_VALID,
  input  logic                    CIN,
  input  logic                    MODE,
  input  logic [cmd_length-1:0]   CMD,
  output logic [2*Width-1:0]      RES,
  output logic                    ERR,
  output logic                    COUT,
  output logic                    OFLOW,
  output logic                    G,
  output logic                    E,
  output logic                    L
);

  localparam int SHW = $clog2(Width);

  logic [3:0]         op_s;
  logic               cmd_hi_s;
  logic [Width:0]     add_s, addc_s, subc_s, inc_a_s, dec_a_s, inc_b_s, dec_b_s;
  logic [Width-1:0]   sub_s, sadd_s, ssub_s, one_s;
  logic [2*Width-1:0] rol_s, ror_s;
  logic [SHW-1:0]     sh_s;
  logic               sh_bad_s;

  logic [1:0]         need_s;
  logic               illegal_s;
  logic               mul_s;
  logic [Width-1:0]   fa_s, fb_s;
  logic [2*Width-1:0] res_s;
  logic               err_s, cout_s, oflow_s, g_s, e_s, l_s;
  logic               mul_go_s;

  logic [Width-1:0]   fa_r, fb_r;
  logic               pend_r;
  logic [2*Width-1:0] prod_s;

  assign op_s     = CMD[3:0];
  assign cmd_hi_s = (CMD >> 3'd4) != {cmd_length{1'b0}};
  assign one_s    = {{(Width-1){1'b0}}, 1'b1};
  assign add_s    = {1'b0, OPA} + {1'b0, OPB};
  assign addc_s   = {1'b0, OPA} + {1'b0, OPB} + {{Width{1'b0}}, CIN};
  assign subc_s   = {1'b0, OPA} - {1'b0, OPB} - {{Width{1'b0}}, CIN};
  assign sub_s    = OPA - OPB;
  assign sadd_s   = OPA + OPB;
  assign ssub_s   = OPA - OPB;
  assign inc_a_s  = {1'b0, OPA} + {1'b0, one_s};
  assign dec_a_s  = {1'b0, OPA} - {1'b0, one_s};
  assign inc_b_s  = {1'b0, OPB} + {1'b0, one_s};
  assign dec_b_s  = {1'b0, OPB} - {1'b0, one_s};
  // Rotates use a doubled copy of A so no variable W-sh shift is needed.
  assign sh_s     = OPB[SHW-1:0];
  assign sh_bad_s = OPB[Width-1:SHW] != {(Width-SHW){1'b0}};
  assign rol_s    = {OPA, OPA} << sh_s;
  assign ror_s    = {OPA, OPA} >> sh_s;
  assign prod_s   = {{Width{1'b0}}, fa_r} * {{Width{1'b0}}, fb_r};

  // Decode the command, compute the next result and flags, then apply error gating.
  always_comb begin
    need_s    = 2'b00;
    illegal_s = 1'b0;
    mul_s     = 1'b0;
    fa_s      = {Width{1'b0}};
    fb_s      = {Width{1'b0}};
    res_s     = {(2*Width){1'b0}};
    err_s     = 1'b0;
    cout_s    = 1'b0;
    oflow_s   = 1'b0;
    g_s       = 1'b0;
    e_s       = 1'b0;
    l_s       = 1'b0;
    if (MODE) begin
      case (op_s)
        4'd0:  begin need_s = 2'b11; res_s = {{(Width-1){1'b0}}, add_s};  cout_s = add_s[Width]; end
        4'd1:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, sub_s};      oflow_s = OPA < OPB; end
        4'd2:  begin need_s = 2'b11; res_s = {{(Width-1){1'b0}}, addc_s}; cout_s = addc_s[Width]; end
        4'd3:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, subc_s[Width-1:0]}; oflow_s = subc_s[Width]; end
        4'd4:  begin need_s = 2'b01; res_s = {{(Width-1){1'b0}}, inc_a_s}; end
        4'd5:  begin need_s = 2'b01; res_s = {{(Width-1){1'b0}}, dec_a_s}; end
        4'd6:  begin need_s = 2'b10; res_s = {{(Width-1){1'b0}}, inc_b_s}; end
        4'd7:  begin need_s = 2'b10; res_s = {{(Width-1){1'b0}}, dec_b_s}; end
        4'd8:  begin
          need_s = 2'b11;
          g_s = OPA > OPB;
          e_s = OPA == OPB;
          l_s = OPA < OPB;
        end
        4'd9:  begin need_s = 2'b11; mul_s = 1'b1; fa_s = OPA + one_s; fb_s = OPB + one_s; end
        4'd10: begin need_s = 2'b11; mul_s = 1'b1; fa_s = {OPA[Width-2:0], 1'b0}; fb_s = OPB; end
        4'd11: begin
          need_s  = 2'b11;
          res_s   = {{Width{1'b0}}, sadd_s};
          oflow_s = (OPA[Width-1] == OPB[Width-1]) && (sadd_s[Width-1] != OPA[Width-1]);
          g_s = $signed(OPA) > $signed(OPB);
          e_s = OPA == OPB;
          l_s = $signed(OPA) < $signed(OPB);
        end
        4'd12: begin
          need_s  = 2'b11;
          res_s   = {{Width{1'b0}}, ssub_s};
          oflow_s = (OPA[Width-1] != OPB[Width-1]) && (ssub_s[Width-1] != OPA[Width-1]);
          g_s = $signed(OPA) > $signed(OPB);
          e_s = OPA == OPB;
          l_s = $signed(OPA) < $signed(OPB);
        end
        default: illegal_s = 1'b1;
      endcase
    end else begin
      case (op_s)
        4'd0:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, OPA & OPB};    end
        4'd1:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, ~(OPA & OPB)}; end
        4'd2:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, OPA | OPB};    end
        4'd3:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, ~(OPA | OPB)}; end
        4'd4:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, OPA ^ OPB};    end
        4'd5:  begin need_s = 2'b11; res_s = {{Width{1'b0}}, ~(OPA ^ OPB)}; end
        4'd6:  begin need_s = 2'b01; res_s = {{Width{1'b0}}, ~OPA};         end
        4'd7:  begin need_s = 2'b10; res_s = {{Width{1'b0}}, ~OPB};         end
        4'd8:  begin need_s = 2'b01; res_s = {{Width{1'b0}}, OPA >> 1'b1};  end
        4'd9:  begin need_s = 2'b01; res_s = {{Width{1'b0}}, OPA << 1'b1};  end
        4'd10: begin need_s = 2'b10; res_s = {{Width{1'b0}}, OPB >> 1'b1};  end
        4'd11: begin need_s = 2'b10; res_s = {{Width{1'b0}}, OPB << 1'b1};  end
        4'd12: begin need_s = 2'b11; res_s = {{Width{1'b0}}, rol_s[2*Width-1:Width]}; end
        4'd13: begin need_s = 2'b11; res_s = {{Width{1'b0}}, ror_s[Width-1:0]};       end
        default: illegal_s = 1'b1;
      endcase
    end
    if (illegal_s || cmd_hi_s || ((INP_VALID & need_s) != need_s) ||
        (!MODE && (op_s == 4'd12 || op_s == 4'd13) && sh_bad_s)) begin
      err_s   = 1'b1;
      mul_s   = 1'b0;
      res_s   = {(2*Width){1'b0}};
      cout_s  = 1'b0;
      oflow_s = 1'b0;
      g_s     = 1'b0;
      e_s     = 1'b0;
      l_s     = 1'b0;
    end else begin
      err_s = 1'b0;
    end
  end

  assign mul_go_s = mul_s;

  // Output registers and multiply pipeline; a non-multiply command discards a pending product.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES    <= {(2*Width){1'b0}};
      ERR    <= 1'b0;
      COUT   <= 1'b0;
      OFLOW  <= 1'b0;
      G      <= 1'b0;
      E      <= 1'b0;
      L      <= 1'b0;
      fa_r   <= {Width{1'b0}};
      fb_r   <= {Width{1'b0}};
      pend_r <= 1'b0;
    end else if (CE) begin
      if (mul_go_s) begin
        fa_r   <= fa_s;
        fb_r   <= fb_s;
        pend_r <= 1'b1;
        if (pend_r) begin
          RES   <= prod_s;
          ERR   <= 1'b0;
          COUT  <= 1'b0;
          OFLOW <= 1'b0;
          G     <= 1'b0;
          E     <= 1'b0;
          L     <= 1'b0;
        end
      end else begin
        pend_r <= 1'b0;
        RES    <= res_s;
        ERR    <= err_s;
        COUT   <= cout_s;
        OFLOW  <= oflow_s;
        G      <= g_s;
        E      <= e_s;
        L      <= l_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_design.sv
// Directed-vector bench for alu_design with hand-computed expected results and flags.
module tb_alu_design;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic [7:0]  OPA, OPB;
  logic [1:0]  INP_VALID;
  logic        CIN, MODE;
  logic [3:0]  CMD;
  logic [15:0] RES;
  logic        ERR, COUT, OFLOW, G, E, L;

  int checks = 0;
  int errors = 0;

  alu_design #(.Width(8), .cmd_length(4)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .OPA(OPA), .OPB(OPB), .INP_VALID(INP_VALID),
    .CIN(CIN), .MODE(MODE), .CMD(CMD), .RES(RES), .ERR(ERR), .COUT(COUT),
    .OFLOW(OFLOW), .G(G), .E(E), .L(L)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flags packed as {ERR,COUT,OFLOW,G,E,L}
  task automatic check_out(input string tag, input logic [15:0] exp_res, input logic [5:0] exp_flags);
    check_eq({tag, ".res"}, {16'd0, RES}, {16'd0, exp_res});
    check_eq({tag, ".flags"}, {26'd0, ERR, COUT, OFLOW, G, E, L}, {26'd0, exp_flags});
  endtask

  task automatic apply(input logic m, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] iv, input logic ci);
    MODE = m; CMD = c; OPA = a; OPB = b; INP_VALID = iv; CIN = ci;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST = 1'b0; CE = 1'b1;
    apply(1'b1, 4'd0, 8'd15, 8'd10, 2'b11, 1'b0);
    #2;
    check_out("reset", 16'h0000, 6'b000000);
    @(negedge CLK);
    RST = 1'b1;
    step(1);
    check_out("add_15_10", 16'd25, 6'b000000);

    apply(1'b1, 4'd0, 8'hFF, 8'hFF, 2'b11, 1'b0); step(1);
    check_out("add_ff_ff", 16'h01FE, 6'b010000);
    apply(1'b1, 4'd1, 8'd20, 8'd10, 2'b11, 1'b0); step(1);
    check_out("sub_20_10", 16'd10, 6'b000000);
    apply(1'b1, 4'd3, 8'd5, 8'd5, 2'b11, 1'b1); step(1);
    check_out("subcin_borrow", 16'h00FF, 6'b001000);
    apply(1'b1, 4'd5, 8'd0, 8'd0, 2'b01, 1'b0); step(1);
    check_out("dec_a_zero", 16'h01FF, 6'b000000);

    apply(1'b1, 4'd9, 8'd4, 8'd3, 2'b11, 1'b0); step(1);
    check_out("mul9_hold", 16'h01FF, 6'b000000);
    step(1);
    check_out("mul9_4_3", 16'd20, 6'b000000);
    apply(1'b1, 4'd9, 8'hFE, 8'hFE, 2'b11, 1'b0); step(2);
    check_out("mul9_fe_fe", 16'hFE01, 6'b000000);
    apply(1'b1, 4'd9, 8'hFF, 8'hFF, 2'b11, 1'b0); step(2);
    check_out("mul9_ff_ff", 16'h0000, 6'b000000);
    apply(1'b1, 4'd10, 8'hFF, 8'hFF, 2'b11, 1'b0); step(2);
    check_out("mul10_ff_ff", 16'hFD02, 6'b000000);
    apply(1'b1, 4'd9, 8'd4, 8'd3, 2'b11, 1'b0); step(1);
    apply(1'b1, 4'd0, 8'd1, 8'd1, 2'b11, 1'b0); step(1);
    check_out("mul_override", 16'd2, 6'b000000);

    apply(1'b1, 4'd11, 8'd127, 8'd1, 2'b11, 1'b0); step(1);
    check_out("sadd_ovf", 16'h0080, 6'b001100);
    apply(1'b1, 4'd12, 8'h80, 8'h7F, 2'b11, 1'b0); step(1);
    check_out("ssub_ovf", 16'h0001, 6'b001001);
    apply(1'b1, 4'd8, 8'd10, 8'd20, 2'b11, 1'b0); step(1);
    check_out("cmp_less", 16'h0000, 6'b000001);
    apply(1'b1, 4'd8, 8'd33, 8'd33, 2'b11, 1'b0); step(1);
    check_out("cmp_equal", 16'h0000, 6'b000010);

    apply(1'b0, 4'd0, 8'hAA, 8'h55, 2'b11, 1'b0); step(1);
    check_out("and", 16'h0000, 6'b000000);
    apply(1'b0, 4'd2, 8'hAA, 8'h55, 2'b11, 1'b0); step(1);
    check_out("or", 16'h00FF, 6'b000000);
    apply(1'b0, 4'd5, 8'hAA, 8'h55, 2'b11, 1'b0); step(1);
    check_out("xnor", 16'h0000, 6'b000000);
    apply(1'b0, 4'd6, 8'hAA, 8'h00, 2'b01, 1'b0); step(1);
    check_out("not_a", 16'h0055, 6'b000000);
    apply(1'b0, 4'd7, 8'hAA, 8'h00, 2'b01, 1'b0); step(1);
    check_out("not_b_missing", 16'h0000, 6'b100000);
    apply(1'b0, 4'd12, 8'h96, 8'd3, 2'b11, 1'b0); step(1);
    check_out("rol", 16'h00B4, 6'b000000);
    apply(1'b0, 4'd13, 8'h69, 8'd2, 2'b11, 1'b0); step(1);
    check_out("ror", 16'h005A, 6'b000000);
    apply(1'b0, 4'd12, 8'h96, 8'h10, 2'b11, 1'b0); step(1);
    check_out("rol_bad_amt", 16'h0000, 6'b100000);

    apply(1'b1, 4'd0, 8'd1, 8'd1, 2'b00, 1'b0); step(1);
    check_out("no_operands", 16'h0000, 6'b100000);
    apply(1'b1, 4'd15, 8'd1, 8'd1, 2'b11, 1'b0); step(1);
    check_out("illegal_cmd", 16'h0000, 6'b100000);

    apply(1'b1, 4'd0, 8'd1, 8'd2, 2'b11, 1'b0); step(1);
    check_out("pre_ce", 16'd3, 6'b000000);
    CE = 1'b0;
    apply(1'b1, 4'd0, 8'hFF, 8'hFF, 2'b11, 1'b0); step(3);
    check_out("ce_hold", 16'd3, 6'b000000);
    CE = 1'b1; step(1);
    check_out("ce_resume", 16'h01FE, 6'b010000);

    #2 RST = 1'b0; #1;
    check_out("async_reset", 16'h0000, 6'b000000);
    @(negedge CLK); RST = 1'b1;

    apply(1'b1, 4'd9, 8'd4, 8'd3, 2'b11, 1'b0); step(1);
    RST = 1'b0; #1;
    RST = 1'b1; step(1);
    check_out("reset_kills_mul", 16'h0000, 6'b000000);
    step(1);
    check_out("mul_after_reset", 16'd20, 6'b000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_design.md
Name: alu_design

Overview:
- Parameterised, registered arithmetic/logic unit with a clock enable, selected by MODE (1 = arithmetic, 0 = logical) and CMD.
- Produces a double-width result, carry, overflow, compare flags and an error flag.
- Used as a single-cycle datapath block; the multiply commands take one extra pipeline cycle.

Parameters:
- Width, 8, operand width W.
- cmd_length, 4, CMD width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- CE  in  1  clock enable; when low, all output registers hold.
- OPA  in  W  operand A.
- OPB  in  W  operand B.
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
- CIN  in  1  carry/borrow in.
- MODE  in  1  1 = arithmetic, 0 = logical.
- CMD  in  cmd_length  operation select.
- RES  out  2W  result, zero-extended.
- ERR  out  1  illegal command, operands missing, or bad rotate amount.
- COUT  out  1  carry out.
- OFLOW  out  1  borrow / signed overflow.
- G, E, L  out  1 each  greater / equal / less flags.

Behaviour:
- Reset (RST=0, async): RES, ERR, COUT, OFLOW, G, E, L all 0; multiply pipeline cleared.
- Inputs are sampled on the rising CLK edge when CE=1.
- Latency: outputs update at that same edge (1 cycle), except CMD 9/10 in MODE=1, which update one edge later (2 cycles).
- Each update sets every flag not defined by the current command to 0.
- Operand requirement per command: two-operand commands need INP_VALID=11; A-only commands need bit0; B-only commands need bit1. If unmet: ERR=1, RES=0, other flags 0.
- MODE=1 commands (W-bit unsigned unless stated):
  - 0 ADD: RES=A+B; COUT=bit W.
  - 1 SUB: RES=A-B (W bits); OFLOW=(A<B).
  - 2 ADD_CIN: RES=A+B+CIN; COUT=bit W.
  - 3 SUB_CIN: RES=A-B-CIN (W bits); OFLOW=borrow.
  - 4 INC_A, 5 DEC_A: A-only; RES=A±1, W+1 bits, no wrap flag.
  - 6 INC_B, 7 DEC_B: B-only; RES=B±1, W+1 bits, no wrap flag.
  - 8 CMP: RES=0; exactly one of G/E/L set, unsigned compare.
  - 9: RES=(A+1)·(B+1); each increment wraps to W bits; product 2W bits.
  - 10: RES=(A<<1 truncated to W)·B; product 2W bits.
  - 11 signed ADD: RES=A+B (W bits, two's complement); OFLOW=signed overflow; G/E/L = signed compare of A vs B.
  - 12 signed SUB: RES=A-B (W bits, two's complement); OFLOW=signed overflow; G/E/L = signed compare of A vs B.
  - 13–15: ERR=1, RES=0.
- MODE=0 commands (RES upper W bits 0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR: two-operand.
  - 6 NOT A: A-only.
  - 7 NOT B: B-only.
  - 8 A>>1, 9 A<<1: A-only, W bits.
  - 10 B>>1, 11 B<<1: B-only, W bits.
  - 12 ROL A by B, 13 ROR A by B: amount = OPB[log2(W)-1:0]; if any higher OPB bit is set, ERR=1 and RES=0.
  - 14–15: ERR=1, RES=0.
- Multiply pipeline: stage 1 registers the two factors, stage 2 registers the product. A new command issued while a multiply is in flight overrides the outputs on its own edge; the pending product is discarded.
- CE=0: no register updates, including the multiply pipeline.
- Reset during a multiply: discards the pending result.

Test Plan:
- Reset, MODE=1 CMD=0, A=15 B=10, INP_VALID=11 -> RES=25, COUT=0.
- MODE=1 CMD=0, A=FF B=FF -> RES=0x1FE, COUT=1. Then CMD=1, A=20 B=10 -> RES=10, OFLOW=0.
- MODE=1 CMD=9, A=4 B=3 -> RES=20 two cycles later. A=FE B=FE -> 0xFE01. A=FF B=FF -> 0. CMD=10, A=FF B=FF -> 0xFD02.
- MODE=1 CMD=11, A=127 B=1 -> RES=0x80, OFLOW=1. CMD=12, A=0x80 B=0x7F -> OFLOW=1. CMD=8, A=10 B=20 -> L=1, G=E=0.
- MODE=0 A=AA B=55: CMD0 -> 00, CMD2 -> FF, CMD5 -> 00. CMD12, A=96 B=3 -> B4. CMD13, A=69 B=2 -> 5A. CMD12, B=0x10 -> ERR=1.
- INP_VALID=00 with CMD=0 -> ERR=1, RES=0. MODE=1 CMD=15 -> ERR=1. CE=0 -> outputs hold. RST low mid-run -> all outputs 0 immediately.
